// File: rtl/vcve2_pkg.sv
// vcve2_pkg: types and constants shared across the vcve2 core slice.
// Holds the OBI request/response bundles used by the data-bus multiplexer.
package vcve2_pkg;

  localparam int unsigned OBI_MUX_MAX_IFS = 8;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // An interface ID needs at least one bit, even when there is a single interface.
  function automatic int unsigned obi_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vcve2_obi_id_fifo.sv
// vcve2_obi_id_fifo: small in-order FIFO of issuer IDs for outstanding OBI transactions.
// Pushes while full and pops while empty are ignored, so callers may drive them unqualified.
module vcve2_obi_id_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      wptr_d = incPtr(wptr_q);
    end
    if (pop_ok) begin
      rptr_d = incPtr(rptr_q);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is only observed through head_o while non-empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vcve2_obi_data_mux.sv
// vcve2_obi_data_mux: round-robin N-to-1 OBI data-bus mux with in-order response routing.
// Optional VCVE2_OBI_MUX_PERF_EN adds per-interface saturating stall counters on perf_stall_o.
module vcve2_obi_data_mux
  import vcve2_pkg::*;
#(
  parameter int unsigned NumIfs         = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumIfs-1:0]        core_req_i,
  output logic [NumIfs-1:0]        core_gnt_o,
  output logic [NumIfs-1:0]        core_rvalid_o,
  input  logic [NumIfs-1:0]        core_we_i,
  input  logic [NumIfs-1:0][3:0]   core_be_i,
  input  logic [NumIfs-1:0][31:0]  core_addr_i,
  input  logic [NumIfs-1:0][31:0]  core_wdata_i,
  output logic [NumIfs-1:0][31:0]  core_rdata_o,
  output logic [NumIfs-1:0]        core_err_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  output logic                     mem_we_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     mem_err_i
`ifdef VCVE2_OBI_MUX_PERF_EN
  ,
  output logic [NumIfs-1:0][15:0]  perf_stall_o
`endif
);

  localparam int unsigned IdW = obi_id_width(NumIfs);

  obi_req_t [NumIfs-1:0] core_pl;
  obi_req_t              win_pl;
  obi_rsp_t              mem_rsp;

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] lock_idx_q, lock_idx_d;
  logic           lock_q, lock_d;
  logic [IdW-1:0] winner;
  logic [IdW-1:0] cand;
  logic           found;
  logic           handshake;
  logic           rsp_valid;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IdW-1:0] fifo_head;

  always_comb begin
    for (int unsigned i = 0; i < NumIfs; i++) begin
      core_pl[i] = '{we: core_we_i[i], be: core_be_i[i], addr: core_addr_i[i],
                     wdata: core_wdata_i[i]};
    end
  end

  // A stalled request keeps its slot so the memory side sees a stable OBI request.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    found  = 1'b0;
    if (lock_q) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumIfs; k++) begin
        cand = IdW'((32'(ptr_q) + k) % NumIfs);
        if (!found && core_req_i[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  assign win_pl      = core_pl[winner];
  assign mem_we_o    = win_pl.we;
  assign mem_be_o    = win_pl.be;
  assign mem_addr_o  = win_pl.addr;
  assign mem_wdata_o = win_pl.wdata;

  // Full is taken from the registered count only; a same-cycle pop does not reopen the port.
  assign mem_req_o = core_req_i[winner] & ~fifo_full;
  assign handshake = mem_req_o & mem_gnt_i;
  assign rsp_valid = mem_rvalid_i & ~fifo_empty;
  assign mem_rsp   = '{rdata: mem_rdata_i, err: mem_err_i};

  always_comb begin
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    if (handshake) begin
      core_gnt_o[winner] = 1'b1;
    end
    if (rsp_valid) begin
      core_rvalid_o[fifo_head] = 1'b1;
    end
    for (int unsigned i = 0; i < NumIfs; i++) begin
      core_rdata_o[i] = mem_rsp.rdata;
      core_err_o[i]   = mem_rsp.err;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      ptr_d  = (winner == IdW'(NumIfs - 1)) ? '0 : winner + IdW'(1);
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  vcve2_obi_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (mem_rvalid_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef VCVE2_OBI_MUX_PERF_EN
  logic [NumIfs-1:0][15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NumIfs; i++) begin
      if (core_req_i[i] && !core_gnt_o[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_o = stall_cnt_q;
`endif

  // A response with nothing outstanding has no owner; it is dropped and flagged.
  orphanResponse : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(mem_rvalid_i && fifo_empty))
    else $warning("orphan mem_rvalid_i dropped: no outstanding transaction");

endmodule

// File: tb/tb_vcve2_obi_data_mux.sv
// tb_vcve2_obi_data_mux: directed vector table, reset sequence and randomized model check
// for the OBI data mux with two interfaces and two outstanding transactions.
module tb_vcve2_obi_data_mux;

  localparam int unsigned NumIfs         = 2;
  localparam int unsigned MaxOutstanding = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NumIfs-1:0]       core_req_i;
  logic [NumIfs-1:0]       core_gnt_o;
  logic [NumIfs-1:0]       core_rvalid_o;
  logic [NumIfs-1:0]       core_we_i;
  logic [NumIfs-1:0][3:0]  core_be_i;
  logic [NumIfs-1:0][31:0] core_addr_i;
  logic [NumIfs-1:0][31:0] core_wdata_i;
  logic [NumIfs-1:0][31:0] core_rdata_o;
  logic [NumIfs-1:0]       core_err_o;
  logic                    mem_req_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic                    mem_we_o;
  logic [3:0]              mem_be_o;
  logic [31:0]             mem_addr_o;
  logic [31:0]             mem_wdata_o;
  logic [31:0]             mem_rdata_i;
  logic                    mem_err_i;
`ifdef VCVE2_OBI_MUX_PERF_EN
  logic [NumIfs-1:0][15:0] perf_stall_o;
`endif

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        expReq;
    logic [1:0]  expGnt;
    logic [1:0]  expRv;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  // Reference state: next-priority interface, stalled-request hold, and issue-order queue.
  int   mPtr;
  bit   mLocked;
  int   mLockIdx;
  int   mQ[$];
  logic [NumIfs-1:0] pending;

  always #5 clk_i = ~clk_i;

  vcve2_obi_data_mux #(
    .NumIfs         (NumIfs),
    .MaxOutstanding (MaxOutstanding)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .core_req_i    (core_req_i),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_we_i     (core_we_i),
    .core_be_i     (core_be_i),
    .core_addr_i   (core_addr_i),
    .core_wdata_i  (core_wdata_i),
    .core_rdata_o  (core_rdata_o),
    .core_err_o    (core_err_o),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i)
`ifdef VCVE2_OBI_MUX_PERF_EN
    ,
    .perf_stall_o  (perf_stall_o)
`endif
  );

  function automatic vec_t mkVec(input logic [1:0] req, input logic gnt, input logic rv,
                                 input logic [31:0] rdata, input logic err, input logic expReq,
                                 input logic [1:0] expGnt, input logic [1:0] expRv,
                                 input logic [31:0] expAddr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
    v.expReq = expReq; v.expGnt = expGnt; v.expRv = expRv; v.expAddr = expAddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NumIfs-1:0] req, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic err);
    core_req_i   = req;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rdata;
    mem_err_i    = err;
  endtask

  task automatic setTablePayload();
    core_addr_i[0] = 32'h0000_0100; core_we_i[0] = 1'b0;
    core_be_i[0]   = 4'hF;          core_wdata_i[0] = 32'hA0A0_A0A0;
    core_addr_i[1] = 32'h0000_0200; core_we_i[1] = 1'b1;
    core_be_i[1]   = 4'h3;          core_wdata_i[1] = 32'hB1B1_B1B1;
  endtask

  function automatic void modelReset();
    mPtr     = 0;
    mLocked  = 1'b0;
    mLockIdx = 0;
    mQ.delete();
    pending  = '0;
  endfunction

  // Leaves the bench at posedge+1 with reset released, the point every step starts from.
  task automatic doReset();
    rst_ni = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    modelReset();
  endtask

  task automatic stepCheck(input string name, input logic [NumIfs-1:0] req, input logic gnt,
                           input logic rv, input logic [31:0] rdata, input logic expReq,
                           input logic [1:0] expGnt, input logic [1:0] expRv);
    applyStimulus(req, gnt, rv, rdata, 1'b0);
    #2;
    checkOutput({name, " mem_req_o"}, 32'(mem_req_o), 32'(expReq));
    checkOutput({name, " core_gnt_o"}, 32'(core_gnt_o), 32'(expGnt));
    checkOutput({name, " core_rvalid_o"}, 32'(core_rvalid_o), 32'(expRv));
    if (expRv != 2'b00) begin
      checkOutput({name, " core_rdata_o"}, core_rdata_o[expRv[1] ? 1 : 0], rdata);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic randomStep(input int cyc);
    int               w;
    bit               full;
    logic             expReq;
    logic [NumIfs-1:0] expGnt;
    logic [NumIfs-1:0] expRv;
    for (int p = 0; p < NumIfs; p++) begin
      if (!pending[p] && ($urandom_range(0, 99) < 40)) begin
        pending[p]      = 1'b1;
        core_addr_i[p]  = $urandom;
        core_we_i[p]    = 1'($urandom_range(0, 1));
        core_be_i[p]    = 4'($urandom_range(0, 15));
        core_wdata_i[p] = $urandom;
      end
    end
    applyStimulus(pending, $urandom_range(0, 99) < 65,
                  (mQ.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3),
                  $urandom, $urandom_range(0, 99) < 10);
    #2;
    full = (mQ.size() >= MaxOutstanding);
    w    = -1;
    if (mLocked) begin
      w = mLockIdx;
    end else begin
      for (int k = 0; k < NumIfs; k++) begin
        if (w < 0 && pending[(mPtr + k) % NumIfs]) w = (mPtr + k) % NumIfs;
      end
    end
    expReq = (w >= 0) && pending[w] && !full;
    expGnt = (expReq && mem_gnt_i) ? NumIfs'(1 << w) : '0;
    expRv  = (mem_rvalid_i && mQ.size() > 0) ? NumIfs'(1 << mQ[0]) : '0;
    checkOutput($sformatf("rnd%0d mem_req_o", cyc), 32'(mem_req_o), 32'(expReq));
    checkOutput($sformatf("rnd%0d core_gnt_o", cyc), 32'(core_gnt_o), 32'(expGnt));
    checkOutput($sformatf("rnd%0d core_rvalid_o", cyc), 32'(core_rvalid_o), 32'(expRv));
    if (expReq) begin
      checkOutput($sformatf("rnd%0d mem_addr_o", cyc), mem_addr_o, core_addr_i[w]);
      checkOutput($sformatf("rnd%0d mem_wdata_o", cyc), mem_wdata_o, core_wdata_i[w]);
      checkOutput($sformatf("rnd%0d mem_we_be", cyc), {27'b0, mem_we_o, mem_be_o},
                  {27'b0, core_we_i[w], core_be_i[w]});
    end
    if (expRv != '0) begin
      checkOutput($sformatf("rnd%0d core_rdata_o", cyc), core_rdata_o[mQ[0]], mem_rdata_i);
      checkOutput($sformatf("rnd%0d core_err_o", cyc), 32'(core_err_o),
                  32'({NumIfs{mem_err_i}}));
    end
    @(posedge clk_i);
    if (expRv != '0) void'(mQ.pop_front());
    if (expGnt != '0) begin
      mQ.push_back(w);
      mPtr       = (w + 1) % NumIfs;
      mLocked    = 1'b0;
      pending[w] = 1'b0;
    end else if (expReq) begin
      mLocked  = 1'b1;
      mLockIdx = w;
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    setTablePayload();

    // Single port, contention, grant stall, full, error and orphan, in that order.
    vecs.push_back(mkVec(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mkVec(2'b01, 1, 0, 32'h0,        0, 1, 2'b01, 2'b00, 32'h100));
    vecs.push_back(mkVec(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mkVec(2'b00, 0, 1, 32'hDEADBEEF, 0, 0, 2'b00, 2'b01, 32'h0));
    vecs.push_back(mkVec(2'b01, 1, 0, 32'h0,        0, 1, 2'b01, 2'b00, 32'h100));
    vecs.push_back(mkVec(2'b11, 1, 1, 32'h11,       0, 1, 2'b10, 2'b01, 32'h200));
    vecs.push_back(mkVec(2'b11, 1, 1, 32'h22,       0, 1, 2'b01, 2'b10, 32'h100));
    vecs.push_back(mkVec(2'b11, 1, 1, 32'h33,       0, 1, 2'b10, 2'b01, 32'h200));
    vecs.push_back(mkVec(2'b00, 0, 1, 32'h44,       0, 0, 2'b00, 2'b10, 32'h0));
    vecs.push_back(mkVec(2'b10, 0, 0, 32'h0,        0, 1, 2'b00, 2'b00, 32'h200));
    vecs.push_back(mkVec(2'b11, 0, 0, 32'h0,        0, 1, 2'b00, 2'b00, 32'h200));
    vecs.push_back(mkVec(2'b11, 0, 0, 32'h0,        0, 1, 2'b00, 2'b00, 32'h200));
    vecs.push_back(mkVec(2'b11, 1, 0, 32'h0,        0, 1, 2'b10, 2'b00, 32'h200));
    vecs.push_back(mkVec(2'b01, 1, 0, 32'h0,        0, 1, 2'b01, 2'b00, 32'h100));
    vecs.push_back(mkVec(2'b01, 1, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mkVec(2'b01, 1, 1, 32'h55,       1, 0, 2'b00, 2'b10, 32'h0));
    vecs.push_back(mkVec(2'b01, 1, 0, 32'h0,        0, 1, 2'b01, 2'b00, 32'h100));
    vecs.push_back(mkVec(2'b00, 0, 1, 32'h66,       0, 0, 2'b00, 2'b01, 32'h0));
    vecs.push_back(mkVec(2'b00, 0, 1, 32'h77,       0, 0, 2'b00, 2'b01, 32'h0));
    vecs.push_back(mkVec(2'b00, 0, 1, 32'h88,       0, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mkVec(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0));

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].err);
      #2;
      checkOutput($sformatf("vec%0d mem_req_o", i), 32'(mem_req_o), 32'(vecs[i].expReq));
      checkOutput($sformatf("vec%0d core_gnt_o", i), 32'(core_gnt_o), 32'(vecs[i].expGnt));
      checkOutput($sformatf("vec%0d core_rvalid_o", i), 32'(core_rvalid_o), 32'(vecs[i].expRv));
      if (vecs[i].expReq) begin
        checkOutput($sformatf("vec%0d mem_addr_o", i), mem_addr_o, vecs[i].expAddr);
        checkOutput($sformatf("vec%0d mem_we_o", i), 32'(mem_we_o),
                    32'(vecs[i].expAddr == 32'h200));
      end
      if (vecs[i].expRv != 2'b00) begin
        checkOutput($sformatf("vec%0d core_rdata_o", i), core_rdata_o[vecs[i].expRv[1] ? 1 : 0],
                    vecs[i].rdata);
        checkOutput($sformatf("vec%0d core_err_o", i), 32'(core_err_o),
                    32'({NumIfs{vecs[i].err}}));
      end
      @(posedge clk_i);
      #1;
    end

    // Reset with two transactions outstanding, then confirm nothing stale survives.
    doReset();
    stepCheck("rst pre0", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    stepCheck("rst pre1", 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00);
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h1234, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("rst in mem_req_o", 32'(mem_req_o), 32'd0);
    checkOutput("rst in core_gnt_o", 32'(core_gnt_o), 32'd0);
    checkOutput("rst in core_rvalid_o", 32'(core_rvalid_o), 32'd0);
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rst in not full", 32'(mem_req_o), 32'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    modelReset();
    stepCheck("rst post orphan", 2'b00, 1'b0, 1'b1, 32'hCAFE, 1'b0, 2'b00, 2'b00);
    stepCheck("rst post ptr", 2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    stepCheck("rst post rsp", 2'b00, 1'b0, 1'b1, 32'h99, 1'b0, 2'b00, 2'b01);

    doReset();
    for (int c = 0; c < 3000; c++) begin
      randomStep(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vcve2_obi_data_mux.md
Name: vcve2_obi_data_mux

Overview:
- N-to-1 OBI data-bus multiplexer directly downstream of the core top's NumIfs data ports.
- Arbitrates the per-interface load/store requests onto one memory-side port.
- Tracks the issuer of each outstanding transaction and routes in-order responses back to that issuer.
- Lets a multi-interface core share a single data memory or interconnect port.

Parameters:
- NumIfs, 2, number of core-side data interfaces (1..8).
- MaxOutstanding, 2, number of accepted-but-unanswered transactions tracked (1..8).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  NumIfs  per-interface request
- core_gnt_o  out  NumIfs  per-interface grant
- core_rvalid_o  out  NumIfs  per-interface response valid
- core_we_i  in  NumIfs  write enable
- core_be_i  in  NumIfs x 4  byte enables
- core_addr_i  in  NumIfs x 32  address
- core_wdata_i  in  NumIfs x 32  write data
- core_rdata_o  out  NumIfs x 32  read data, replicated to every port and qualified by core_rvalid_o
- core_err_o  out  NumIfs  error, replicated and qualified by core_rvalid_o
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_we_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  error

Behaviour:
- Reset clears:
  - round-robin pointer to 0
  - lock flag to 0
  - ID FIFO to empty (count 0, read and write pointers 0)
- With no requests after reset: mem_req_o=0, core_gnt_o=0, core_rvalid_o=0.
- Arbitration is combinational round-robin:
  - Winner is the first asserted core_req_i at or after the pointer, scanning upward with modulo-NumIfs wrap.
  - Winner's we/be/addr/wdata drive mem_*.
  - mem_req_o = core_req_i[winner] & ~fifo_full.
- Grant:
  - core_gnt_o[winner] = mem_gnt_i & mem_req_o.
  - All other grants are 0.
  - Zero-latency request path; no payload registering.
- Lock, needed for OBI request stability:
  - If mem_req_o=1 and mem_gnt_i=0, register the winner index and set the lock.
  - While locked, the winner is the locked index regardless of pointer or other requests.
  - The lock clears on handshake.
- Handshake (mem_req_o & mem_gnt_i):
  - Push the winner index into the ID FIFO.
  - Pointer becomes (winner+1) mod NumIfs.
- Response:
  - On mem_rvalid_i, pop the FIFO head.
  - core_rvalid_o[head]=1 in the same cycle (zero latency).
  - rdata and err pass straight through.
- FIFO full (count==MaxOutstanding):
  - mem_req_o forced 0 and no grants, even if a pop occurs that cycle. This keeps the full flag registered-only.
- Simultaneous push and pop when not full: count unchanged, both pointers advance. Pointers wrap modulo MaxOutstanding.
- mem_rvalid_i with empty FIFO: protocol violation. The response is dropped, FIFO state is unchanged, and an assertion fires.
- Reset mid-operation returns to the reset state. Responses for pre-reset transactions are not delivered.
- NumIfs==1: arbitration degenerates to pass-through, but FIFO occupancy limiting still applies.

Optional Feature:
- Macro: VCVE2_OBI_MUX_PERF_EN.
- When defined, adds output perf_stall_o (NumIfs x 16).
- Per interface, a saturating counter increments each cycle core_req_i=1 and core_gnt_o=0.
- Counters reset to 0 and saturate at 16'hFFFF.
- When undefined, the port and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Add to vcve2_pkg:
  - typedef obi_req_t {we, be[3:0], addr[31:0], wdata[31:0]}
  - typedef obi_rsp_t {rdata[31:0], err}
  - constant OBI_MUX_MAX_IFS=8
- Sub-module vcve2_obi_id_fifo:
  - Parameterised width $clog2(NumIfs) (minimum 1) and depth MaxOutstanding.
  - push/pop/full/empty/head interface.

Test Plan:
- Single port: port0 req addr 0x100, mem_gnt_i same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> core_gnt_o=2'b01 same cycle; core_rvalid_o=2'b01 with rdata 0xDEADBEEF.
- Contention: ports 0 and 1 request continuously, mem_gnt_i=1 always, responses returned promptly -> grants alternate 0,1,0,1; responses route 0,1,0,1.
- Grant stall: port1 wins, mem_gnt_i low 3 cycles while port0 raises req -> mem_addr_o stays port1's address until granted; port0 granted next.
- Full: MaxOutstanding=2, two grants without rvalid -> mem_req_o=0 with port0 req high; one rvalid -> mem_req_o reasserts the following cycle.
- Error and orphan: rvalid with err=1 for port1's transaction -> core_err_o=1 with core_rvalid_o[1]. rvalid on empty FIFO -> no core_rvalid_o and an assertion fires.
- Reset mid-operation: assert rst_ni low with 2 transactions outstanding -> count 0, pointer 0, all outputs 0; post-reset rvalid is dropped.
